buf_capture_ctrl: RTL and testbench

Write-side controller that feeds the capture buffer's write port (wdata/waddr/wen) and monitors its full flag. Arms on software command, waits for a trigger edge, skips a programmable delay, then writes a programmable number of decimated samples from a streaming source. Sits directly upstream of the capture buffer in the write-clock domain; reports status to host registers.

---
 rtl/buf_capture_ctrl_if.sv | 14 +
 rtl/buf_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_buf_capture_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/buf_capture_ctrl_if.sv
// Capture buffer write port: data, address, write strobe and full flag.
// The controller drives the master side; the buffer sits on the slave side.
interface buf_capture_ctrl_if #(
    parameter int DW  = 8,
    parameter int AWW = 8
);
    logic [DW-1:0]  wdata;
    logic [AWW-1:0] waddr;
    logic           wen;
    logic           buf_full;

    modport master (output wdata, waddr, wen, input buf_full);
    modport slave  (input wdata, waddr, wen, output buf_full);
endinterface

// File: rtl/buf_capture_ctrl.sv
// Capture write-side controller: arm, trigger, delay, decimated capture.
// Optional CAPTURE_TSTAMP_EN adds a trigger timestamp output.
module buf_capture_ctrl #(
    parameter int DW   = 8,
    parameter int AWW  = 8,
    parameter int DECW = 16,
    parameter int DLYW = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            arm,
    input  logic            abort,
    input  logic            trig_in,
    input  logic            sw_trig,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    input  logic [DECW-1:0] decim,
    input  logic [DLYW-1:0] delay,
    input  logic [AWW:0]    length,
    buf_capture_ctrl_if.master wr,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [2:0]      state
`ifdef CAPTURE_TSTAMP_EN
    ,
    output logic [31:0]     trig_tstamp
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_CAP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [AWW:0]    CNT_ONE = 1;
    localparam logic [DLYW-1:0] DLY_ONE = 1;
    localparam logic [DECW-1:0] DEC_ONE = 1;

    state_e          state_q, state_d;
    logic            trig_q;
    logic [DECW-1:0] dec_q, dec_d, decim_q, decim_d;
    logic [DLYW-1:0] dly_q, dly_d, delay_q, delay_d;
    logic [AWW:0]    cnt_q, cnt_d, len_q, len_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AWW-1:0]  waddr_q, waddr_d;
    logic            wen_q, wen_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            trig;
    logic [AWW:0]    len_eff;

    assign trig    = (trig_in & ~trig_q) | sw_trig;
    assign len_eff = (len_q == '0) ? {1'b1, {AWW{1'b0}}} : len_q;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        decim_d = decim_q;
        delay_d = delay_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        wen_d   = 1'b0;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        waddr_d = '0;
                        cnt_d   = '0;
                        dec_d   = '0;
                        dly_d   = '0;
                        decim_d = decim;
                        delay_d = delay;
                        len_d   = length;
                    end
                end
                S_ARMED: begin
                    if (trig)
                        state_d = (delay_q != '0) ? S_DELAY : S_CAP;
                end
                S_DELAY: begin
                    if (din_valid) begin
                        if (dly_q + DLY_ONE == delay_q)
                            state_d = S_CAP;
                        else
                            dly_d = dly_q + DLY_ONE;
                    end
                end
                S_CAP: begin
                    if (din_valid) begin
                        if (dec_q == '0) begin
                            wen_d   = 1'b1;
                            wdata_d = din;
                            waddr_d = cnt_q[AWW-1:0];
                            cnt_d   = cnt_q + CNT_ONE;
                            dec_d   = decim_q;
                            if (cnt_q + CNT_ONE == len_eff) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            dec_d = dec_q - DEC_ONE;
                        end
                    end
                    // A full buffer ends capture unless this sample completed it.
                    if (wr.buf_full && state_d == S_CAP) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) ||
                 (state_d == S_CAP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            dec_q   <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            decim_q <= '0;
            delay_q <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_in;
            dec_q   <= dec_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            decim_q <= decim_d;
            delay_q <= delay_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr.wdata = wdata_q;
    assign wr.waddr = waddr_q;
    assign wr.wen   = wen_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign state    = state_q;

`ifdef CAPTURE_TSTAMP_EN
    logic [31:0] ts_q, tstamp_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q     <= '0;
            tstamp_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (!abort && state_q == S_ARMED && trig)
                tstamp_q <= ts_q;
        end
    end

    assign trig_tstamp = tstamp_q;
`endif

endmodule

// File: tb/tb_buf_capture_ctrl.sv
// Randomized bench for buf_capture_ctrl against a sample-list reference model.
module tb_buf_capture_ctrl;

    localparam int DW  = 8;
    localparam int AWW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          arm = 1'b0, abort = 1'b0;
    logic          trig_in = 1'b0, sw_trig = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [15:0]   decim = '0, delay = '0;
    logic [AWW:0]  length = '0;
    logic          busy, done, ovf;
    logic [2:0]    state;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int             e;
        logic [DW-1:0]  d;
        logic [AWW-1:0] a;
    } wr_t;

    wr_t           got[$];
    logic [DW-1:0] sd[$];
    int            sit[$];

    buf_capture_ctrl_if #(.DW(DW), .AWW(AWW)) wr_if ();

    buf_capture_ctrl #(.DW(DW), .AWW(AWW), .DECW(16), .DLYW(16)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .abort(abort),
        .trig_in(trig_in), .sw_trig(sw_trig), .din(din),
        .din_valid(din_valid), .decim(decim), .delay(delay),
        .length(length), .wr(wr_if.master), .busy(busy), .done(done),
        .ovf(ovf), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] g,
                       input logic [63:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, g, e);
        end
    endtask

    task automatic do_arm(input int dc, input int dl, input int ln);
        @(negedge clk);
        arm = 1'b1; decim = 16'(dc); delay = 16'(dl); length = 5'(ln);
        trig_in = 1'b0; sw_trig = 1'b0; abort = 1'b0;
        din = 8'($urandom); din_valid = 1'($urandom);
        @(negedge clk);
        arm = 1'b0;
        decim = 16'($urandom); delay = 16'($urandom); length = 5'($urandom);
        din = 8'($urandom);
    endtask

    task automatic run(input int dc, input int dl, input int ln,
                       input bit sw, input int full_after, input int vpct);
        int  full_it, len_eff, nexp;
        bit  fin, exp_ovf;
        sd.delete(); sit.delete(); got.delete();
        full_it = -1;
        fin = 1'b0;
        do_arm(dc, dl, ln);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            din = 8'($urandom); din_valid = 1'($urandom);
        end
        chk("armed_state", state, 3'd1);
        if (sw) sw_trig = 1'b1;
        else trig_in = 1'b1;
        din = 8'($urandom); din_valid = 1'($urandom);
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            if (wr_if.wen) got.push_back('{cyc, wr_if.wdata, wr_if.waddr});
            if (done) fin = 1'b1;
            if (!fin) begin
                trig_in = 1'($urandom);
                sw_trig = ($urandom_range(0, 7) == 0);
                din = 8'($urandom);
                din_valid = ($urandom_range(0, 99) < vpct);
                arm = busy && ($urandom_range(0, 9) == 0);
                if (full_after > 0 && got.size() >= full_after &&
                    full_it < 0) begin
                    wr_if.buf_full = 1'b1;
                    full_it = cyc + 1;
                end
                if (din_valid) begin
                    sd.push_back(din);
                    sit.push_back(cyc + 1);
                end
            end
        end
        chk("done_timeout", fin, 1'b1);
        // Skip the delay samples, then keep every (decim+1)-th valid sample.
        len_eff = (ln == 0) ? (1 << AWW) : ln;
        nexp = 0;
        for (int i = dl; i < sd.size() && nexp < len_eff; i++) begin
            if (full_it >= 0 && sit[i] > full_it) break;
            if ((i - dl) % (dc + 1) == 0) begin
                if (nexp < got.size()) begin
                    chk("wdata", got[nexp].d, sd[i]);
                    chk("waddr", got[nexp].a, nexp % (1 << AWW));
                    chk("latency", got[nexp].e, sit[i]);
                end
                nexp++;
            end
        end
        exp_ovf = (full_it >= 0) && (nexp < len_eff);
        chk("write_count", got.size(), (full_it < 0) ? len_eff : nexp);
        chk("ovf", ovf, exp_ovf);
        chk("done_state", state, 3'd4);
        chk("done_busy", busy, 1'b0);
        arm = 1'b0; sw_trig = 1'b0; trig_in = 1'b0;
        din_valid = 1'b1; wr_if.buf_full = 1'b0;
        @(negedge clk);
        chk("post_done_wen", wr_if.wen, 1'b0);
        din_valid = 1'b0;
    endtask

    task automatic abort_test();
        int n;
        n = 0;
        do_arm(0, 0, 10);
        sw_trig = 1'b1; din_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            sw_trig = 1'b0;
            if (wr_if.wen) n++;
            din = 8'($urandom); din_valid = 1'b1;
            if (n == 2) break;
        end
        chk("abort_prewrites", n, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; din_valid = 1'b0;
        chk("abort_state", state, 3'd0);
        chk("abort_wen", wr_if.wen, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
    endtask

    task automatic reset_test();
        int n;
        n = 0;
        do_arm(0, 0, 12);
        sw_trig = 1'b1; din_valid = 1'b1;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge clk);
            sw_trig = 1'b0;
            if (wr_if.wen) n++;
            din = 8'($urandom);
        end
        trig_in = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_wen", wr_if.wen, 1'b0);
        chk("rst_waddr", wr_if.waddr, '0);
        chk("rst_wdata", wr_if.wdata, '0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        arm = 1'b1; decim = '0; delay = '0; length = 5'd4;
        @(negedge clk);
        arm = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (wr_if.wen) n++;
        end
        chk("stale_trig_state", state, 3'd1);
        chk("stale_trig_wen", n, 0);
        trig_in = 1'b0;
        @(negedge clk);
        trig_in = 1'b1;
        @(negedge clk);
        chk("fresh_edge_state", state, 3'd3);
        abort = 1'b1; din_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0; trig_in = 1'b0;
    endtask

    initial begin
        wr_if.buf_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", state, 3'd0);
        chk("reset_wen", wr_if.wen, 1'b0);
        chk("reset_waddr", wr_if.waddr, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_ovf", ovf, 1'b0);
        resetn = 1'b1;
        run(0, 0, 4, 1'b0, 0, 100);
        run(2, 0, 3, 1'b0, 0, 100);
        run(0, 5, 2, 1'b1, 0, 100);
        run(0, 0, 8, 1'b1, 3, 100);
        abort_test();
        run(1, 2, 5, 1'b0, 0, 70);
        run(1, 2, 0, 1'b1, 0, 80);
        for (int r = 0; r < 14; r++) begin
            run($urandom_range(0, 3), $urandom_range(0, 12),
                $urandom_range(0, 16), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                $urandom_range(30, 100));
        end
        reset_test();
        run(0, 1, 6, 1'b0, 0, 90);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
